// File: rtl/mmi_pkg.sv
// Shared constants, FSM state type and access decode for the MMI bus master.
package mmi_pkg;

  localparam logic [7:0] DATA_BASE = 8'h80;
  localparam logic [7:0] SET_ADDR  = 8'h00;
  localparam logic [7:0] SEL_ADDR  = 8'h02;
  localparam logic [7:0] RD_BASE   = 8'h0C;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STROBE = 2'd1;
  localparam state_t ST_GAP    = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam logic [2:0] LAST_STEP = 3'd4;

  // One byte-bus access: direction, address and write data.
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } access_t;

  // Decode which access a command performs at a given step.
  // Writes: four data bytes LSB first, then the index to SET_ADDR.
  // Reads: the index to SEL_ADDR, then four result bytes LSB first.
  function automatic access_t access_for(input logic        is_wr,
                                         input logic [4:0]  idx,
                                         input logic [31:0] wdata,
                                         input logic [2:0]  step);
    access_t a;
    a = '0;
    if (is_wr) begin
      a.wr = 1'b1;
      if (step == LAST_STEP) begin
        a.addr  = SET_ADDR;
        a.wdata = {3'b000, idx};
      end else begin
        a.addr  = DATA_BASE + {5'b00000, step};
        a.wdata = wdata[{step[1:0], 3'b000} +: 8];
      end
    end else if (step == 3'd0) begin
      a.wr    = 1'b1;
      a.addr  = SEL_ADDR;
      a.wdata = {3'b000, idx};
    end else begin
      a.wr    = 1'b0;
      a.addr  = RD_BASE + {5'b00000, step - 3'd1};
      a.wdata = 8'h00;
    end
    return a;
  endfunction

endpackage

// File: rtl/mmi_bus_master.sv
// Converts 32-bit register write / input read commands into a sequence of
// five strobed byte-bus accesses, each followed by GAP_CYCLES idle cycles.
module mmi_bus_master
  import mmi_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [4:0]  cmd_index_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [7:0]  bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  input  logic [7:0]  bus_rdata_i,
  output logic        bus_wr_o,
  output logic        bus_rd_o
);

  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  gap_q, gap_d;
  logic        wr_q, wr_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  access_t     acc;
  logic [1:0]  lane;
  logic        on_bus;

  // Every access is decoded from the latched command only, so a single
  // command can never mix index values across its accesses.
  assign acc    = access_for(wr_q, idx_q, wdata_q, step_q);
  assign lane   = step_q[1:0] - 2'd1;
  assign on_bus = (state_q == ST_STROBE) || (state_q == ST_GAP);

  // Bus outputs are decoded straight from state, so reset drops them at once.
  assign bus_wr_o    = (state_q == ST_STROBE) &&  acc.wr;
  assign bus_rd_o    = (state_q == ST_STROBE) && !acc.wr;
  assign bus_addr_o  = on_bus ? acc.addr  : 8'h00;
  assign bus_wdata_o = on_bus ? acc.wdata : 8'h00;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_DONE);
  assign rsp_rdata_o = rsp_rdata_q;

  // Next-state logic: command latch, step/gap sequencing and read capture.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    gap_d       = gap_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    shadow_d    = shadow_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          wr_d    = cmd_write_i;
          idx_d   = cmd_index_i;
          wdata_d = cmd_wdata_i;
          step_d  = 3'd0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        gap_d   = 2'd0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // Read data is taken at the end of the first gap cycle.
        if (gap_q == 2'd0 && !acc.wr) begin
          shadow_d[{lane, 3'b000} +: 8] = bus_rdata_i;
        end
        if (gap_q == GAP_LAST) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            if (!wr_q) rsp_rdata_d = shadow_d;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ST_STROBE;
          end
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      gap_q       <= 2'd0;
      wr_q        <= 1'b0;
      idx_q       <= 5'd0;
      wdata_q     <= 32'd0;
      shadow_q    <= 32'd0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      gap_q       <= gap_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      shadow_q    <= shadow_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mmi_bus_master.sv
// Scoreboard bench: stimulus pushes expected bus accesses and responses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mmi_bus_master;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } bev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DUT with the default gap
  logic        cmd_valid = 0, cmd_write = 0;
  logic [4:0]  cmd_index = 0;
  logic [31:0] cmd_wdata = 0;
  logic        cmd_ready, rsp_valid, bus_wr, bus_rd;
  logic [31:0] rsp_rdata;
  logic [7:0]  bus_addr, bus_wdata;
  logic [7:0]  bus_rdata = 0;

  mmi_bus_master #(.GAP_CYCLES(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_write_i(cmd_write), .cmd_index_i(cmd_index), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
    .bus_wr_o(bus_wr), .bus_rd_o(bus_rd)
  );

  // DUT with the widest gap
  logic        g_valid = 0, g_write = 0;
  logic [4:0]  g_index = 0;
  logic [31:0] g_wdata_in = 0;
  logic        g_ready, g_rsp, g_wr, g_rd;
  logic [31:0] g_rdata;
  logic [7:0]  g_addr, g_wdata;

  mmi_bus_master #(.GAP_CYCLES(3)) u_gap3 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(g_valid), .cmd_ready_o(g_ready),
    .cmd_write_i(g_write), .cmd_index_i(g_index), .cmd_wdata_i(g_wdata_in),
    .rsp_valid_o(g_rsp), .rsp_rdata_o(g_rdata),
    .bus_addr_o(g_addr), .bus_wdata_o(g_wdata), .bus_rdata_i(8'h00),
    .bus_wr_o(g_wr), .bus_rd_o(g_rd)
  );

  // Reference model state
  bev_t        exp_bus[$];
  logic [31:0] exp_rsp[$];
  int          acc_q[$];
  int          acc_log[$];
  int          rsp_log[$];
  logic [31:0] rd_mem[32];
  logic [31:0] last_rd = 0;
  int          sel_idx = 0;
  int          strb_n = 0;
  int          last_strb = 0;
  logic        prev_strb = 0;

  // Monitor: pops expectations on every strobe / response; also acts as
  // the byte-bus slave that serves read data from rd_mem.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
      end
      if (bus_wr && bus_rd) begin
        errors++;
        $display("FAIL strobe_overlap wr=%b rd=%b both high (cycle %0d)", bus_wr, bus_rd, cyc);
      end
      if (prev_strb && (bus_wr || bus_rd)) begin
        errors++;
        $display("FAIL strobe_width strobe high two cycles in a row (cycle %0d)", cyc);
      end
      if (bus_wr || bus_rd) begin
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe addr %h (cycle %0d)", bus_addr, cyc);
        end else begin
          bev_t e;
          e = exp_bus.pop_front();
          chk("bus_dir_wr", {31'b0, bus_wr}, {31'b0, e.wr});
          chk("bus_addr", {24'b0, bus_addr}, {24'b0, e.addr});
          if (e.wr) chk("bus_wdata", {24'b0, bus_wdata}, {24'b0, e.data});
        end
        if (strb_n % 5 == 0) begin
          if (acc_q.size() != 0) chk("first_strobe_latency", cyc - acc_q[0], 1);
        end else begin
          chk("strobe_spacing", cyc - last_strb, 2);
        end
        last_strb = cyc;
        strb_n++;
        if (bus_wr && bus_addr == 8'h02) sel_idx = int'(bus_wdata[4:0]);
        if (bus_rd) begin
          int off;
          off = int'(bus_addr) - 12;
          if (off >= 0 && off < 4) bus_rdata = rd_mem[sel_idx][off*8 +: 8];
        end
      end
      if (rsp_valid) begin
        rsp_log.push_back(cyc);
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp rdata %h (cycle %0d)", rsp_rdata, cyc);
        end else begin
          logic [31:0] r;
          r = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, r);
        end
        if (acc_q.size() != 0) begin
          int a;
          a = acc_q.pop_front();
          chk("rsp_latency", cyc - a, 11);
        end
      end
    end
    prev_strb = rst_n && (bus_wr || bus_rd);
  end

  // Recorder for the wide-gap instance
  int          g_strb[$];
  logic [15:0] g_acc_seen[$];
  int          g_rsp_cyc = -1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (g_wr || g_rd) begin
        g_strb.push_back(cyc);
        g_acc_seen.push_back({g_addr, g_wdata});
      end
      if (g_rsp) g_rsp_cyc = cyc;
    end
  end

  // Issue one command; expectations are queued before it is driven.
  task automatic send(input logic w, input logic [4:0] idx, input logic [31:0] d, input logic hold);
    int n;
    if (w) begin
      for (int k = 0; k < 4; k++) exp_bus.push_back({1'b1, 8'(8'h80 + k), d[k*8 +: 8]});
      exp_bus.push_back({1'b1, 8'h00, {3'b000, idx}});
    end else begin
      exp_bus.push_back({1'b1, 8'h02, {3'b000, idx}});
      for (int k = 0; k < 4; k++) exp_bus.push_back({1'b0, 8'(8'h0C + k), 8'h00});
      last_rd = rd_mem[idx];
    end
    exp_rsp.push_back(last_rd);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_index = idx; cmd_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout cmd_ready %b after %0d cycles", cmd_ready, n);
    end
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_write = $urandom_range(0, 1);
      cmd_index = 5'($urandom);
      cmd_wdata = $urandom;
    end
  endtask

  // Pulse cmd_valid with junk while the DUT is busy; it must be ignored.
  task automatic noise_pulse();
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_index = 5'($urandom); cmd_wdata = $urandom;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_bus.size() != 0 || exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout bus left %0d rsp left %0d", exp_bus.size(), exp_rsp.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int g_acc;
    logic [4:0] gi;
    for (int i = 0; i < 32; i++) rd_mem[i] = $urandom;
    rd_mem[3] = 32'h89ABCDEF;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_bus_wr", {31'b0, bus_wr}, 0);
    chk("rst_bus_rd", {31'b0, bus_rd}, 0);
    chk("rst_bus_addr", {24'b0, bus_addr}, 0);
    chk("rst_bus_wdata", {24'b0, bus_wdata}, 0);
    chk("rst_g_ready", {31'b0, g_ready}, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed write and read
    send(1'b1, 5'd5, 32'h12345678, 1'b0);
    noise_pulse();
    drain();
    send(1'b0, 5'd3, 32'h0, 1'b0);
    drain();
    chk("read_idx3_value", rsp_rdata, 32'h89ABCDEF);

    // Back-to-back with cmd_valid held high
    send(1'b1, 5'd0, $urandom, 1'b1);
    send(1'b0, 5'd31, 32'h0, 1'b0);
    drain();
    if (acc_log.size() >= 1 && rsp_log.size() >= 2)
      chk("b2b_accept_after_rsp", acc_log[acc_log.size()-1] - rsp_log[rsp_log.size()-2], 1);
    else begin
      errors++;
      $display("FAIL b2b_logs acc %0d rsp %0d entries", acc_log.size(), rsp_log.size());
    end

    // Reset during step 2 of a write
    send(1'b1, 5'd9, 32'hA5A5_5A5A, 1'b0);
    n = 0;
    while (!(bus_wr && bus_addr == 8'h82) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(bus_wr && bus_addr == 8'h82)) begin
      errors++;
      $display("FAIL reset_test_step2 never reached, addr %h", bus_addr);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr_drop", {31'b0, bus_wr}, 0);
    chk("rst_async_rd_drop", {31'b0, bus_rd}, 0);
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 0);
    exp_bus.delete(); exp_rsp.delete(); acc_q.delete();
    strb_n = 0;
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_hold_rsp_valid", {31'b0, rsp_valid}, 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 1);
    send(1'b1, 5'd17, 32'hCAFEF00D, 1'b0);
    drain();

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      logic w, h;
      w = 1'($urandom_range(0, 1));
      h = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      send(w, 5'($urandom), $urandom, h);
      if (!h) repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    #1;
    cmd_valid = 1'b0;
    drain();

    // Wide gap instance
    gi = 5'($urandom);
    @(posedge clk); #1;
    g_valid = 1'b1; g_write = 1'b1; g_index = gi; g_wdata_in = 32'hFFFFFFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!g_ready && n < 100);
    g_acc = cyc;
    @(posedge clk); #1;
    g_valid = 1'b0;
    n = 0;
    while (g_rsp_cyc < 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("g3_strobe_count", g_strb.size(), 5);
    if (g_strb.size() == 5 && g_rsp_cyc >= 0) begin
      chk("g3_first_strobe", g_strb[0] - g_acc, 1);
      for (int k = 1; k < 5; k++) chk("g3_spacing", g_strb[k] - g_strb[k-1], 4);
      for (int k = 0; k < 4; k++) chk("g3_access", {16'b0, g_acc_seen[k]}, {16'b0, 8'(8'h80 + k), 8'hFF});
      chk("g3_set_access", {16'b0, g_acc_seen[4]}, {16'b0, 8'h00, 3'b000, gi});
      chk("g3_rsp_latency", g_rsp_cyc - g_acc, 21);
    end else begin
      errors++;
      $display("FAIL g3_sequence strobes %0d rsp cycle %0d", g_strb.size(), g_rsp_cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmi_bus_master.md
MMI_BUS_MASTER -- requirements
Module: mmi_bus_master

Interface
REQ-001 Parameter GAP_CYCLES, default 1: idle bus cycles inserted after every strobe cycle, legal range 1..3.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-006 cmd_write  in  1  1 = write register, 0 = read input.
REQ-007 cmd_index  in  5  register or input index, 0..31.
REQ-008 cmd_wdata  in  32  write value.
REQ-009 rsp_valid  out  1  one-cycle pulse marking command completion.
REQ-010 rsp_rdata  out  32  read result, held until the next read completes.
REQ-011 bus_addr  out  8  byte-bus address.
REQ-012 bus_wdata  out  8  byte-bus write data.
REQ-013 bus_rdata  in  8  byte-bus read data.
REQ-014 bus_wr  out  1  one-cycle write strobe.
REQ-015 bus_rd  out  1  one-cycle read strobe.

Function
REQ-016 FSM states SHALL be IDLE, STROBE, GAP, DONE; a 3-bit step counter SHALL select the current access, 0..4.
REQ-017 cmd_ready SHALL be high only in IDLE; on acceptance, cmd_write, cmd_index and cmd_wdata SHALL be latched, and the FSM SHALL move to STROBE with step=0.
REQ-018 Write sequence: steps 0..3 write wdata byte k to address DATA_BASE+k, LSB first; step 4 writes {3'b0,index} to SET_ADDR.
REQ-019 Read sequence: step 0 writes {3'b0,index} to SEL_ADDR; steps 1..4 read address RD_BASE+(step-1), LSB first.
REQ-020 In STROBE, exactly one of bus_wr/bus_rd SHALL be high for exactly one cycle, with bus_addr and bus_wdata valid in that same cycle.
REQ-021 In GAP, both strobes SHALL be low, and bus_addr and bus_wdata SHALL hold their STROBE values.
REQ-022 For read steps, bus_rdata SHALL be captured into byte lane (step-1) of a shadow register at the clock edge that ends the first GAP cycle.
REQ-023 After GAP_CYCLES gap cycles, the FSM SHALL go to STROBE with step+1, or to DONE if step==4.
REQ-024 DONE SHALL last one cycle, with rsp_valid=1; on a read, rsp_rdata SHALL be updated from the shadow register on entry to DONE; the FSM then returns to IDLE.
REQ-025 Latency with GAP_CYCLES=1: first strobe in the cycle after acceptance; rsp_valid 11 cycles after the accepting edge for both writes and reads.
REQ-026 Commands SHALL be accepted back-to-back: a cmd_valid held high is accepted in the IDLE cycle that immediately follows DONE.
REQ-027 cmd_valid that falls without a handshake SHALL be ignored; command inputs SHALL NOT be sampled outside IDLE.
REQ-028 Each access SHALL drive a single index value, taken from the latched copy, so one command can never drive a mixed index.

Reset
REQ-029 While reset is low: FSM=IDLE, step=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0, bus_wr=0, bus_rd=0, bus_addr=0, bus_wdata=0.
REQ-030 Reset asserted mid-command SHALL abort the command immediately with no rsp_valid; strobes SHALL drop asynchronously, and the first post-reset strobe SHALL belong to a new command.

Structure
REQ-031 Package mmi_pkg SHALL hold DATA_BASE=8'h80, SET_ADDR=8'h00, SEL_ADDR=8'h02, RD_BASE=8'h0C, and the FSM state typedef.
REQ-032 There SHALL be no sub-module; the block is a single FSM plus a datapath of about 200 lines.

Verification
REQ-033 Write idx=5, wdata=32'h12345678 -> bus_wr at addresses 80,81,82,83,00 with data 78,56,34,12,05; strobes spaced 2 cycles apart; rsp_valid 11 cycles after acceptance.
REQ-034 Read idx=3 while the bench model returns bytes EF,CD,AB,89 -> SEL write data 03, then bus_rd at 0C..0F; rsp_rdata=32'h89ABCDEF.
REQ-035 cmd_valid held high for write idx=0 followed by read idx=31 -> second acceptance in the cycle after the first rsp_valid; no strobe overlap; SEL data 1F.
REQ-036 reset pulsed low during step 2 of a write -> strobes go low at once, no rsp_valid, cmd_ready=1 after release; a new write completes correctly.
REQ-037 GAP_CYCLES=3, write 32'hFFFFFFFF -> strobes spaced 4 cycles apart; rsp_valid 21 cycles after acceptance.
REQ-038 All runs -> assertion never fires for bus_wr and bus_rd high together, or for any strobe lasting more than one cycle.
